training_sample_sequencer: RTL and testbench

Stimulus source directly upstream of the perceptron core. In TRAIN mode it walks a truth-table dataset for a fixed number of epochs and presents each sample and its label over a valid/ready handshake. It then switches to INFER mode and presents debounced board switch inputs as sfp values. It also drives the core's `training` flag, so the top level no longer embeds the epoch loop.

---
 rtl/training_sample_sequencer_pkg.sv | 26 ++
 rtl/training_sample_sequencer_debouncer.sv | 47 ++++
 rtl/training_sample_sequencer.sv | 156 +++++++++++++++
 tb/tb_training_sample_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/training_sample_sequencer_pkg.sv
// Shared types and helpers for the training sample sequencer and its users.
//   sfp          : signed Q8.8 fixed-point value used by the perceptron core
//   ONE, HALF    : fixed-point constants
//   seq_state_t  : sequencer state (IDLE, TRAIN, INFER)
//   bit_to_sfp() : maps a binary input onto 0 or ONE
package training_sample_sequencer_pkg;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = sfp'(1 << SFP_FRAC);
  localparam sfp HALF = sfp'(1 << (SFP_FRAC - 1));

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    INFER
  } seq_state_t;

  function automatic sfp bit_to_sfp(input logic b);
    return b ? ONE : '0;
  endfunction

endpackage

// File: rtl/training_sample_sequencer_debouncer.sv
// One-bit switch debouncer: 2-flop synchroniser followed by a stability counter.
//   clk  : clock
//   rst  : synchronous active-high reset (dout returns to 0)
//   din  : raw asynchronous switch input
//   dout : debounced level; follows din only after it has differed from dout
//          for DEBOUNCE_CYCLES consecutive cycles
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == dout_q) begin
        // Agreement (including a glitch that returned) restarts the count.
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        dout_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/training_sample_sequencer.sv
// Stimulus source for the perceptron core. TRAIN walks the truth-table dataset
// for NUM_EPOCHS passes over a valid/ready handshake, then INFER presents the
// debounced switches. All outputs come straight from registers.
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : in IDLE, begin training
//   retrain_i        : in INFER, restart training from epoch 0 (beats a handshake)
//   sw_in_i          : raw switch inputs
//   out_ready_i      : consumer accepts the presented sample
//   out_valid_o      : values_o / expected_o are valid
//   values_o         : INPUT_UNITS sfp values, element j at [j*SFP_W +: SFP_W]
//   expected_o       : label (0 or ONE); 0 in INFER
//   training_o       : high in TRAIN
//   sample_idx_o     : current dataset index
//   epoch_count_o    : completed epochs, held at NUM_EPOCHS through INFER
//   train_done_o     : one-cycle pulse on entry to INFER
module training_sample_sequencer
  import training_sample_sequencer_pkg::*;
#(
  parameter int INPUT_UNITS     = 2,
  parameter int NUM_EPOCHS      = 10,
  parameter logic [(2**INPUT_UNITS)-1:0] TRUTH_TABLE = 4'b1000,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int IDX_W = $clog2(2**INPUT_UNITS),
  localparam int VAL_W = INPUT_UNITS * SFP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   retrain_i,
  input  logic [INPUT_UNITS-1:0] sw_in_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [VAL_W-1:0]       values_o,
  output logic [SFP_W-1:0]       expected_o,
  output logic                   training_o,
  output logic [IDX_W-1:0]       sample_idx_o,
  output logic [7:0]             epoch_count_o,
  output logic                   train_done_o
);

  logic [INPUT_UNITS-1:0] sw_db;

  for (genvar g = 0; g < INPUT_UNITS; g++) begin : g_db
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_in_i[g]),
      .dout (sw_db[g])
    );
  end

  // Element j is driven by index bit (INPUT_UNITS-1-j): element 0 is the MSB.
  function automatic logic [VAL_W-1:0] train_values(input logic [IDX_W-1:0] idx);
    logic [VAL_W-1:0] v;
    for (int j = 0; j < INPUT_UNITS; j++) v[j*SFP_W +: SFP_W] = bit_to_sfp(idx[INPUT_UNITS-1-j]);
    return v;
  endfunction

  function automatic logic [VAL_W-1:0] infer_values(input logic [INPUT_UNITS-1:0] sw);
    logic [VAL_W-1:0] v;
    for (int j = 0; j < INPUT_UNITS; j++) v[j*SFP_W +: SFP_W] = bit_to_sfp(sw[j]);
    return v;
  endfunction

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       epoch_q, epoch_d, epoch_inc;
  logic [VAL_W-1:0] values_q, values_d;
  logic [SFP_W-1:0] expected_q, expected_d;
  logic             done_q, done_d;
  logic             hs;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    values_d   = values_q;
    expected_d = expected_q;
    done_d     = 1'b0;
    hs         = (state_q != IDLE) && out_ready_i;
    epoch_inc  = epoch_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = TRAIN;
          idx_d      = '0;
          epoch_d    = '0;
          values_d   = train_values('0);
          expected_d = bit_to_sfp(TRUTH_TABLE[0]);
        end
      end
      TRAIN: begin
        if (hs) begin
          idx_d = idx_q + IDX_W'(1);  // last index wraps to 0
          if (idx_q == '1) begin
            epoch_d = epoch_inc;
            if (epoch_inc == 8'(NUM_EPOCHS)) begin
              state_d = INFER;
              done_d  = 1'b1;
            end
          end
          // The handshake is consumed; load whatever the next cycle presents.
          if (state_d == INFER) begin
            values_d   = infer_values(sw_db);
            expected_d = '0;
          end else begin
            values_d   = train_values(idx_d);
            expected_d = bit_to_sfp(TRUTH_TABLE[idx_d]);
          end
        end
      end
      INFER: begin
        if (retrain_i) begin
          state_d    = TRAIN;
          idx_d      = '0;
          epoch_d    = '0;
          values_d   = train_values('0);
          expected_d = bit_to_sfp(TRUTH_TABLE[0]);
        end else if (hs) begin
          values_d = infer_values(sw_db);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      epoch_q    <= '0;
      values_q   <= '0;
      expected_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      values_q   <= values_d;
      expected_q <= expected_d;
      done_q     <= done_d;
    end
  end

  assign out_valid_o   = (state_q != IDLE);
  assign training_o    = (state_q == TRAIN);
  assign values_o      = values_q;
  assign expected_o    = expected_q;
  assign sample_idx_o  = idx_q;
  assign epoch_count_o = epoch_q;
  assign train_done_o  = done_q;

endmodule

// File: tb/tb_training_sample_sequencer.sv
module tb_training_sample_sequencer;

  localparam logic [15:0] ONE_V = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, retrain_i, out_ready_i;
  logic [1:0]  sw_in_i;
  logic        out_valid_o, training_o, train_done_o;
  logic [31:0] values_o;
  logic [15:0] expected_o;
  logic [1:0]  sample_idx_o;
  logic [7:0]  epoch_count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  training_sample_sequencer #(
    .INPUT_UNITS(2), .NUM_EPOCHS(2), .TRUTH_TABLE(4'b1000), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .retrain_i(retrain_i),
    .sw_in_i(sw_in_i), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
    .values_o(values_o), .expected_o(expected_o), .training_o(training_o),
    .sample_idx_o(sample_idx_o), .epoch_count_o(epoch_count_o),
    .train_done_o(train_done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bench model of the dataset: element 0 = idx bit 1, element 1 = idx bit 0, AND label.
  function automatic logic [31:0] pat(input logic [1:0] idx);
    return {(idx[0] ? ONE_V : 16'h0), (idx[1] ? ONE_V : 16'h0)};
  endfunction

  function automatic logic [15:0] lbl(input logic [1:0] idx);
    return (idx == 2'd3) ? ONE_V : 16'h0;
  endfunction

  function automatic logic [60:0] all_outs();
    return {out_valid_o, training_o, train_done_o, sample_idx_o, epoch_count_o,
            expected_o, values_o};
  endfunction

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic        training;
    logic [1:0]  idx;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] expd;
    logic [7:0]  epoch;
    logic        done;
  } vec_t;

  vec_t vec [11];

  initial begin
    logic [1:0] m_idx;
    logic [7:0] m_ep;
    int hs_cnt, done_cnt;
    bit fin, seen;
    logic r;

    //        start ready | valid train idx  v0     v1     exp    ep  done
    vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0, ONE_V, 16'h0, 8'd0, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, ONE_V, 16'h0, 16'h0, 8'd0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, ONE_V, ONE_V, ONE_V, 8'd0, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, 8'd1, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0, ONE_V, 16'h0, 8'd1, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, ONE_V, 16'h0, 16'h0, 8'd1, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, ONE_V, ONE_V, ONE_V, 8'd1, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 8'd2, 1'b1};
    vec[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 8'd2, 1'b0};

    rst = 1'b1; start_i = 1'b0; retrain_i = 1'b0; out_ready_i = 1'b0; sw_in_i = 2'b00;
    #1;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset with no start.
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle_outs[%0d]", i), 64'(all_outs()), 64'h0);
    end

    // Two full epochs with out_ready held high; start in row 3 must be ignored.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("r%0d_valid", i), 64'(out_valid_o), 64'(vec[i].valid));
      check($sformatf("r%0d_train", i), 64'(training_o), 64'(vec[i].training));
      check($sformatf("r%0d_idx", i), 64'(sample_idx_o), 64'(vec[i].idx));
      check($sformatf("r%0d_vals", i), 64'(values_o), 64'({vec[i].v1, vec[i].v0}));
      check($sformatf("r%0d_exp", i), 64'(expected_o), 64'(vec[i].expd));
      check($sformatf("r%0d_epoch", i), 64'(epoch_count_o), 64'(vec[i].epoch));
      check($sformatf("r%0d_done", i), 64'(train_done_o), 64'(vec[i].done));
      start_i = vec[i].start;
      out_ready_i = vec[i].ready;
      step();
    end
    start_i = 1'b0;

    // INFER debounce: sw[1] rises; values element 1 follows after sync+4+load.
    sw_in_i = 2'b10;
    repeat (6) step();
    check("db_too_early", 64'(values_o), 64'h0);
    step();
    check("db_values", 64'(values_o), 64'({ONE_V, 16'h0}));
    check("db_infer_exp", 64'(expected_o), 64'h0);

    // Two-cycle glitch on sw[0] never reaches values.
    sw_in_i = 2'b11;
    repeat (2) step();
    sw_in_i = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (values_o !== {ONE_V, 16'h0}) seen = 1'b1;
    end
    check("glitch_ignored", 64'(seen), 64'h0);

    // retrain together with a handshake: retrain wins, idx 0 presented next.
    retrain_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    retrain_i = 1'b0;
    check("rt_training", 64'(training_o), 64'h1);
    check("rt_idx", 64'(sample_idx_o), 64'h0);
    check("rt_epoch", 64'(epoch_count_o), 64'h0);
    check("rt_vals", 64'(values_o), 64'(pat(2'd0)));
    check("rt_exp", 64'(expected_o), 64'(lbl(2'd0)));

    // Random stalls: every presented sample must match the model's next sample.
    m_idx = 2'd0; m_ep = 8'd0; hs_cnt = 0; done_cnt = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (!training_o) begin
        fin = 1'b1;
      end else begin
        check("st_idx", 64'(sample_idx_o), 64'(m_idx));
        check("st_vals", 64'(values_o), 64'(pat(m_idx)));
        check("st_exp", 64'(expected_o), 64'(lbl(m_idx)));
        check("st_epoch", 64'(epoch_count_o), 64'(m_ep));
        if (train_done_o) done_cnt++;
        r = 1'($urandom_range(0, 1));
        out_ready_i = r;
        if (r && out_valid_o) begin
          hs_cnt++;
          if (m_idx == 2'd3) m_ep = m_ep + 8'd1;
          m_idx = m_idx + 2'd1;
        end
        step();
      end
    end
    check("st_finished", 64'(fin), 64'h1);
    check("st_handshakes", 64'(hs_cnt), 64'd8);
    check("st_early_done", 64'(done_cnt), 64'h0);
    check("st_done_pulse", 64'(train_done_o), 64'h1);
    check("st_final_epoch", 64'(epoch_count_o), 64'd2);
    check("st_infer_valid", 64'(out_valid_o), 64'h1);

    // Back to TRAIN, advance to epoch 1 idx 2, then reset mid-stream.
    out_ready_i = 1'b0;
    retrain_i = 1'b1;
    step();
    retrain_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) step();
    out_ready_i = 1'b0;
    check("mid_idx", 64'(sample_idx_o), 64'd2);
    check("mid_epoch", 64'(epoch_count_o), 64'd1);

    // retrain and start outside their states are ignored.
    retrain_i = 1'b1;
    start_i = 1'b1;
    step();
    retrain_i = 1'b0;
    start_i = 1'b0;
    check("ign_idx", 64'(sample_idx_o), 64'd2);
    check("ign_epoch", 64'(epoch_count_o), 64'd1);
    check("ign_training", 64'(training_o), 64'h1);

    rst = 1'b1;
    out_ready_i = 1'b1;
    step();
    check("rst_outs", 64'(all_outs()), 64'h0);
    rst = 1'b0;
    step();
    check("post_rst_idle", 64'(all_outs()), 64'h0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("restart_train", 64'(training_o), 64'h1);
    check("restart_idx", 64'(sample_idx_o), 64'h0);
    check("restart_epoch", 64'(epoch_count_o), 64'h0);
    check("restart_vals", 64'(values_o), 64'(pat(2'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
